// File: rtl/nibble_serial_addsub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/sub controller.
package nibble_serial_addsub_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_addsub_ctrl_addsub_nibble.sv
// One nibble of ripple-carry addition; subtraction is done by the caller
// pre-inverting b and feeding cin=1.
module addsub_nibble
    import nibble_serial_addsub_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] s,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar g = 0; g < NIB_W; g++) begin : g_fa
        assign s[g]   = a[g] ^ b[g] ^ c[g];
        assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_addsub_ctrl.sv
// Sequences a single 4-bit add/sub slice over WIDTH/4 cycles, LS nibble first,
// and reports result, final carry/no-borrow and signed overflow.
module nibble_serial_addsub_ctrl
    import nibble_serial_addsub_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cbout,
    output logic             ovf
);

    localparam int unsigned NNIB  = WIDTH / NIB_W;
    localparam int unsigned IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;

    if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and at least 8");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
    logic               sub_q, sub_d, carry_q, carry_d;
    logic               cbout_q, cbout_d, ovf_q, ovf_d;
    logic               ready_q, ready_d, done_q, done_d;

    logic [NIB_W-1:0]   nib_a, nib_b, nib_sum;
    logic               nib_cout, last_nib;

    assign nib_a    = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_b    = b_q[idx_q*NIB_W +: NIB_W] ^ {NIB_W{sub_q}};
    assign last_nib = (idx_q == IDX_W'(NNIB - 1));

    addsub_nibble u_nib (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cbout_q  <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cbout_q  <= cbout_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        result_d = result_q;
        cbout_d  = cbout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b;
                    sub_d    = sub;
                    idx_d    = '0;
                    result_d = '0;
                    carry_d  = sub;
                    cbout_d  = 1'b0;
                    ovf_d    = 1'b0;
                end
            end
            RUN: begin
                result_d[idx_q*NIB_W +: NIB_W] = nib_sum;
                carry_d = nib_cout;
                idx_d   = IDX_W'(idx_q + 1'b1);
                if (last_nib) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cbout_d = nib_cout;
                    // Overflow: operands agree in sign but the result does not.
                    ovf_d   = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ sub_q))
                            & (nib_sum[NIB_W-1] != a_q[WIDTH-1]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == DONE);
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign cbout  = cbout_q;
    assign ovf    = ovf_q;

endmodule
